// File: rtl/kyber_arith_pkg.sv
// Shared Kyber arithmetic types and constants for the coefficient datapath.
package kyber_arith_pkg;

    localparam int          COEFF_W = 12;
    localparam logic [12:0] KYBER_Q = 13'd3329;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

endpackage

// File: rtl/modq_addsub_lane.sv
// Single-coefficient (a +/- b) mod q with one conditional subtraction of q.
// Optional out-of-range flag when POLY_ADDSUB_RANGE_CHECK_EN is defined.
module modq_addsub_lane
    import kyber_arith_pkg::*;
#(
    parameter logic [12:0] Q = KYBER_Q
) (
    input  logic [COEFF_W-1:0] i_a,
    input  logic [COEFF_W-1:0] i_b,
    input  logic               i_op,
    output logic [COEFF_W-1:0] o_r
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
    ,
    output logic               o_oor
`endif
);

    logic [12:0] w_sum;

    // Subtract path adds q first so canonical inputs never go negative.
    always_comb begin
        if (i_op) w_sum = {1'b0, i_a} + Q - {1'b0, i_b};
        else      w_sum = {1'b0, i_a} + {1'b0, i_b};
    end

    assign o_r = (w_sum >= Q) ? COEFF_W'(w_sum - Q) : w_sum[COEFF_W-1:0];

`ifdef POLY_ADDSUB_RANGE_CHECK_EN
    assign o_oor = ({1'b0, i_a} >= Q) || ({1'b0, i_b} >= Q);
`endif

endmodule

// File: rtl/poly_addsub_modq.sv
// Multi-cycle polynomial add/sub mod q, LANES coefficients per cycle.
// Optional sticky range_err output with POLY_ADDSUB_RANGE_CHECK_EN.
module poly_addsub_modq #(
    parameter int KYBER_N = 256,
    parameter int KYBER_Q = 3329,
    parameter int LANES   = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         op,
    input  logic [KYBER_N*kyber_arith_pkg::COEFF_W-1:0]  a_in,
    input  logic [KYBER_N*kyber_arith_pkg::COEFF_W-1:0]  b_in,
    output logic                                         busy,
    output logic                                         done,
    output logic [KYBER_N*kyber_arith_pkg::COEFF_W-1:0]  result
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
    ,
    output logic                                         range_err
`endif
);

    localparam int CW      = kyber_arith_pkg::COEFF_W;
    localparam int POLY_W  = KYBER_N * CW;
    localparam int CHUNK_W = LANES * CW;
    localparam int NCHUNK  = KYBER_N / LANES;
    localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    kyber_arith_pkg::addsub_state_t r_state, w_state_nxt;

    logic [POLY_W-1:0]  r_a, r_b, r_result;
    logic               r_op, r_busy, r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept, w_run;
    logic [CHUNK_W-1:0] w_a_chunk, w_b_chunk, w_res_chunk;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            kyber_arith_pkg::IDLE: begin
                if (start) begin
                    w_state_nxt = kyber_arith_pkg::RUN;
                    w_accept    = 1'b1;
                end
            end
            kyber_arith_pkg::RUN: begin
                w_run = 1'b1;
                if (r_cnt == LAST_CNT) w_state_nxt = kyber_arith_pkg::DONE;
            end
            kyber_arith_pkg::DONE: begin
                if (start) begin
                    w_state_nxt = kyber_arith_pkg::RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = kyber_arith_pkg::IDLE;
                end
            end
            default: w_state_nxt = kyber_arith_pkg::IDLE;
        endcase
    end

    // busy/done are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= kyber_arith_pkg::IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == kyber_arith_pkg::RUN);
            r_done  <= (w_state_nxt == kyber_arith_pkg::DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_op  <= op;
            r_cnt <= '0;
        end else if (w_run) begin
            r_result[r_cnt*CHUNK_W +: CHUNK_W] <= w_res_chunk;
            r_cnt                              <= r_cnt + 1'b1;
        end
    end

    assign w_a_chunk = r_a[r_cnt*CHUNK_W +: CHUNK_W];
    assign w_b_chunk = r_b[r_cnt*CHUNK_W +: CHUNK_W];

`ifdef POLY_ADDSUB_RANGE_CHECK_EN
    logic [LANES-1:0] w_oor;
    logic             r_range_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_range_err <= 1'b0;
        else if (w_accept)       r_range_err <= 1'b0;
        else if (w_run && |w_oor) r_range_err <= 1'b1;
    end

    assign range_err = r_range_err;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        modq_addsub_lane #(
            .Q(13'(KYBER_Q))
        ) u_lane (
            .i_a  (w_a_chunk[g*CW +: CW]),
            .i_b  (w_b_chunk[g*CW +: CW]),
            .i_op (r_op),
            .o_r  (w_res_chunk[g*CW +: CW])
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
            ,
            .o_oor(w_oor[g])
`endif
        );
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_poly_addsub_modq.sv
// Directed bench for poly_addsub_modq; range_err scenarios run when
// POLY_ADDSUB_RANGE_CHECK_EN is defined.
module tb_poly_addsub_modq;

    localparam int N  = 256;
    localparam int Q  = 3329;
    localparam int CW = 12;
    localparam int PW = N * CW;

    logic          clk = 1'b0;
    logic          rst, start, op;
    logic [PW-1:0] a_in, b_in, result;
    logic          busy, done;
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
    logic          range_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    poly_addsub_modq #(.KYBER_N(N), .KYBER_Q(Q), .LANES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
        ,
        .range_err(range_err)
`endif
    );

    function automatic logic [PW-1:0] fill(input int v);
        logic [PW-1:0] p;
        for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(v);
        return p;
    endfunction

    function automatic int coeff(input logic [PW-1:0] p, input int i);
        return int'(p[i*CW +: CW]);
    endfunction

    function automatic int ref_modq(input logic o, input int a, input int b);
        if (o) return (a - b + Q) % Q;
        return (a + b) % Q;
    endfunction

    function automatic int first_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
        for (int i = 0; i < N; i++) if (x[i*CW +: CW] !== y[i*CW +: CW]) return i;
        return 0;
    endfunction

    task automatic start_op(input logic o, input logic [PW-1:0] a, input logic [PW-1:0] b);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result coeff0 got %0d want 0", coeff(result, 0)); end
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
        checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL reset_range_err got %b want 0", range_err); end
`endif
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_add_timing();
        logic [PW-1:0] exp;
        exp = fill(171);
        start_op(1'b0, fill(3000), fill(500));
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL add_busy cycle %0d got busy=%b done=%b want busy=1 done=0", k, busy, done);
            end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL add_done_edge16 got done=%b busy=%b want done=1 busy=0", done, busy); end
        checks++; if (result !== exp) begin failures++; $display("FAIL add_result coeff %0d got %0d want 171", first_diff(result, exp), coeff(result, first_diff(result, exp))); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got %b want 0", done); end
    endtask

    task automatic test_sub_vectors();
        int sa[3] = '{5, 1234, 3328};
        int sb[3] = '{10, 1234, 0};
        int se[3] = '{3324, 0, 3328};
        logic [PW-1:0] a, b, exp;
        int n, d;
        for (int t = 0; t < 3; t++) begin
            exp = fill(se[t]);
            start_op(1'b1, fill(sa[t]), fill(sb[t]));
            wait_done(n);
            checks++; if (n != 16) begin failures++; $display("FAIL sub_latency[%0d] got %0d want 16", t, n); end
            checks++;
            if (result !== exp) begin
                d = first_diff(result, exp); failures++;
                $display("FAIL sub_uniform[%0d] coeff %0d got %0d want %0d", t, d, coeff(result, d), se[t]);
            end
        end
        for (int i = 0; i < N; i++) begin
            a[i*CW +: CW] = CW'(i * 10);
            b[i*CW +: CW] = CW'(3000 - i);
            exp[i*CW +: CW] = CW'(ref_modq(1'b1, i * 10, 3000 - i));
        end
        start_op(1'b1, a, b);
        wait_done(n);
        checks++;
        if (result !== exp) begin
            d = first_diff(result, exp); failures++;
            $display("FAIL sub_packing coeff %0d got %0d want %0d", d, coeff(result, d), coeff(exp, d));
        end
    endtask

    task automatic test_boundaries();
        logic bo[3] = '{1'b0, 1'b0, 1'b1};
        int   ba[3] = '{3328, 3328, 0};
        int   bb[3] = '{1, 3328, 3328};
        int   be[3] = '{0, 3327, 1};
        logic [PW-1:0] exp;
        int n, d;
        for (int t = 0; t < 3; t++) begin
            exp = fill(be[t]);
            start_op(bo[t], fill(ba[t]), fill(bb[t]));
            wait_done(n);
            checks++;
            if (result !== exp) begin
                d = first_diff(result, exp); failures++;
                $display("FAIL boundary[%0d] coeff %0d got %0d want %0d", t, d, coeff(result, d), be[t]);
            end
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] a, b, exp;
        int n, d, va, vb;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                va = int'($urandom_range(Q - 1));
                vb = int'($urandom_range(Q - 1));
                a[i*CW +: CW] = CW'(va);
                b[i*CW +: CW] = CW'(vb);
                exp[i*CW +: CW] = CW'(ref_modq(t[0], va, vb));
            end
            start_op(t[0], a, b);
            wait_done(n);
            checks++;
            if (result !== exp) begin
                d = first_diff(result, exp); failures++;
                $display("FAIL random[%0d] coeff %0d got %0d want %0d", t, d, coeff(result, d), coeff(exp, d));
            end
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0, pos = 0;
        logic [PW-1:0] cap, exp;
        exp = fill(300);
        cap = '0;
        start_op(1'b0, fill(100), fill(200));
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin start = 1'b1; op = 1'b1; a_in = fill(7); b_in = fill(9); end
            if (k == 6) start = 1'b0;
            if (done === 1'b1) begin ndone++; if (ndone == 1) begin pos = k; cap = result; end end
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
        checks++; if (pos != 16) begin failures++; $display("FAIL ignored_done_pos got %0d want 16", pos); end
        checks++; if (cap !== exp) begin failures++; $display("FAIL ignored_result coeff0 got %0d want 300", coeff(cap, 0)); end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] e1, e2;
        int n;
        e1 = fill(2000);
        e2 = fill(2329);
        start_op(1'b0, fill(1000), fill(1000));
        wait_done(n);
        checks++; if (n != 16 || result !== e1) begin failures++; $display("FAIL b2b_first got n=%0d coeff0=%0d want n=16 coeff0=2000", n, coeff(result, 0)); end
        start_op(1'b1, fill(1000), fill(2000));
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_rearm got busy=%b done=%b want busy=1 done=0", busy, done); end
        checks++; if (result !== e1) begin failures++; $display("FAIL b2b_hold coeff0 got %0d want 2000", coeff(result, 0)); end
        wait_done(n);
        checks++; if (n != 16) begin failures++; $display("FAIL b2b_latency got %0d want 16", n); end
        checks++; if (result !== e2) begin failures++; $display("FAIL b2b_second coeff0 got %0d want 2329", coeff(result, 0)); end
    endtask

    task automatic test_operand_change();
        logic [PW-1:0] exp;
        int n;
        exp = fill(3);
        start_op(1'b0, fill(1), fill(2));
        a_in = fill(3000); b_in = fill(3000); op = 1'b1;
        wait_done(n);
        checks++; if (result !== exp) begin failures++; $display("FAIL operand_change coeff0 got %0d want 3", coeff(result, 0)); end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] exp;
        int n;
        exp = fill(10);
        start_op(1'b0, fill(10), fill(20));
        repeat (7) @(posedge clk);
        #1;
        checks++; if (coeff(result, 0) != 30) begin failures++; $display("FAIL partial_written got %0d want 30", coeff(result, 0)); end
        checks++; if (coeff(result, 255) != 3) begin failures++; $display("FAIL partial_kept got %0d want 3", coeff(result, 255)); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_ctrl got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (result !== '0) begin failures++; $display("FAIL midreset_result coeff0 got %0d want 0", coeff(result, 0)); end
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
        checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL midreset_range_err got %b want 0", range_err); end
`endif
        @(posedge clk); #1; rst = 1'b0;
        start_op(1'b1, fill(20), fill(10));
        wait_done(n);
        checks++; if (n != 16 || result !== exp) begin failures++; $display("FAIL after_reset got n=%0d coeff0=%0d want n=16 coeff0=10", n, coeff(result, 0)); end
    endtask

`ifdef POLY_ADDSUB_RANGE_CHECK_EN
    task automatic test_range_err();
        logic [PW-1:0] a;
        int n;
        a = fill(0);
        a[7*CW +: CW] = 12'hFFF;
        start_op(1'b0, a, fill(0));
        wait_done(n);
        checks++; if (range_err !== 1'b1) begin failures++; $display("FAIL range_err_set got %b want 1", range_err); end
        checks++; if (coeff(result, 7) != 766) begin failures++; $display("FAIL range_err_value got %0d want 766", coeff(result, 7)); end
        start_op(1'b0, fill(1), fill(1));
        wait_done(n);
        checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL range_err_clear got %b want 0", range_err); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        test_reset();
        test_add_timing();
        test_sub_vectors();
        test_boundaries();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_operand_change();
        test_reset_mid();
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
        test_range_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poly_addsub_modq.md
# poly_addsub_modq

Multi-cycle Kyber polynomial add/subtract unit with modular reduction. It sits directly downstream of the operand multiplexer in the arithmetic path and consumes the selected pair of 256-coefficient polynomials. It produces the coefficient-wise result (a ± b) mod q. The unit processes LANES coefficients per cycle, so one adder lane can be replicated rather than instantiating a full-width adder.

## Interface
Parameters:
- `KYBER_N`, default 256 from params.vh: coefficients per polynomial.
- `KYBER_Q`, default 3329 from params.vh: modulus.
- `LANES`, default 16: coefficients processed per cycle. Must divide KYBER_N and be a power of two.

Ports:
- `clk`, input, 1 bit: single clock, rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `start`, input, 1 bit: request. Sampled only while `busy`=0.
- `op`, input, 1 bit: 0 = add, 1 = subtract (a − b). Latched with `start`.
- `a_in`, input, KYBER_N*12 bits: operand a. Coefficient i occupies bits [12i+11:12i]. Latched with `start`.
- `b_in`, input, KYBER_N*12 bits: operand b, same packing as `a_in`. Latched with `start`.
- `busy`, output, 1 bit: operation in progress.
- `done`, output, 1 bit: one-cycle pulse; `result` is complete.
- `result`, output, KYBER_N*12 bits: result polynomial, same packing as the operands.
- `range_err`, output, 1 bit: present only with the range-check macro.

## Operation
States: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1. On that edge, latch `a_in`, `b_in` and `op`, and clear chunk counter `cnt`.
- RUN processes chunk `cnt`, i.e. coefficients [cnt*LANES, cnt*LANES+LANES−1].
  - Each RUN edge writes that chunk into `result` and increments `cnt`.
  - The edge that writes the last chunk (cnt = KYBER_N/LANES−1) moves the FSM to DONE.
- DONE lasts exactly one cycle, then returns to IDLE.
  - If `start`=1 in DONE, the FSM goes directly to RUN (back-to-back operation).

Arithmetic per lane (inputs 12 bits, internal values 13 bits):
- Add: s = a + b. If s ≥ q, the output is s − q; otherwise s.
- Sub: d = a + q − b. If d ≥ q, the output is d − q; otherwise d.
- For a, b ∈ [0, q−1] the output is canonical, in [0, q−1].
- For inputs ≥ q the output is the formula above truncated to 12 bits; it is not guaranteed canonical.

Other rules:
- `start` while `busy`=1 is ignored. Latched operands and the counter are unaffected.
- `a_in` and `b_in` may change freely after the start edge. The upstream mux is free to reselect.
- `result` holds its value from `done` until the next accepted start.
  - Chunks are then overwritten progressively.
  - Result bits outside the chunks written so far keep their previous values.
- `rst` takes effect mid-operation immediately:
  - FSM goes to IDLE.
  - `busy`, `done` and `range_err` go to 0.
  - `result` and the latched operands go to 0.
  - The counter goes to 0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `range_err`=0.
- Start sampled at edge 0:
  - `busy`=1 after edge 0.
  - Chunk k is written at edge k+1.
  - `done`=1 and `busy`=0 after edge KYBER_N/LANES (edge 16 at the defaults).
  - `done` returns to 0 after the following edge unless the operation is re-armed.
- Latency: KYBER_N/LANES cycles from the start edge to `done`. Throughput: one operation per KYBER_N/LANES cycles with back-to-back starts.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `POLY_ADDSUB_RANGE_CHECK_EN` defined:
  - The `range_err` port exists.
  - Each lane flags any latched a or b coefficient ≥ KYBER_Q.
  - `range_err` is sticky: it clears on an accepted start and is valid when `done` rises.
  - The result is still computed as specified above.
- Macro undefined: no `range_err` port and no compare logic.

## Structure
- Shared package `kyber_arith_pkg` contains:
  - `COEFF_W` = 12.
  - `KYBER_Q` as a 13-bit constant.
  - The `addsub_state_t` enum (IDLE, RUN, DONE).
  - The `coeff_t` typedef.
- Sub-module `modq_addsub_lane`: combinational single-coefficient add/sub with conditional subtraction of q, plus the optional ≥q flag. It is instantiated LANES times.
- The top level holds the FSM, counter, operand registers and chunk write-back.

## Test plan
- Add: all a=3000, b=500 → all result=171. `done` after exactly 16 cycles; `busy` high for cycles 1–16.
- Sub: a=5, b=10 → 3324. a=b=1234 → 0. a=3328, b=0 → 3328. Check each coefficient index for packing.
- Boundaries: add 3328+1 → 0; add 3328+3328 → 3327; sub 0−3328 → 1. Random canonical vectors are checked against a reference (a±b) mod 3329.
- Handshake: pulse `start` again at cycle 5 of RUN → ignored, single `done`. Start asserted during the DONE cycle → second result with `done` 16 cycles later. Change `a_in` after the start edge → no effect.
- Reset at cycle 8 of RUN → `busy`=0, `done`=0 and `result`=0 immediately. A new start then completes correctly.
- With `POLY_ADDSUB_RANGE_CHECK_EN`: one a coefficient = 4095 → `range_err`=1 at `done`. The next canonical operation → `range_err`=0.
